// File: rtl/renas_mcu_pkg.sv
// Shared types and constants for the autonomous SPI echo master.
package renas_mcu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_e;

    localparam logic [7:0]  RESET_TX   = 8'hA5;
    localparam int unsigned NUM_SLAVES = 4;

    // Active-low one-hot select pattern for slave idx
    function automatic logic [NUM_SLAVES-1:0] sel_decode(input logic [1:0] idx);
        logic [NUM_SLAVES-1:0] sel;
        sel      = '1;
        sel[idx] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/renas_spi_shifter.sv
// SPI mode-0 bit engine: clock divider, sclk generation and tx/rx shift registers.
// load presents the tx MSB, start launches the 16 sclk edges, done marks the last
// falling edge and commit echoes the received byte into tx and parks mosi low.
module renas_spi_shifter
    import renas_mcu_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic start,
    input  logic commit,
    input  logic miso,
    output logic sclk,
    output logic mosi,
    output logic done
);

    localparam int unsigned       EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);

    logic [7:0]        div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              running;
    logic              sclk_q;
    logic              mosi_q;
    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-1:0] rx_reg;
    logic              tick;
    logic [EDGE_W-2:0] next_bit;

    // Divider expiry marks an sclk edge; the last one ends the frame's shifting
    assign tick = running && (div_cnt == DIV_LAST);
    assign done = tick && (edge_cnt == LAST_EDGE);

    // Falling edge k (k = 1..7) presents bit DATA_W-1-k; edge_cnt[..:1] is k-1 there
    assign next_bit = (EDGE_W - 1)'(DATA_W - 2) - edge_cnt[EDGE_W-1:1];

    // Divider, sclk toggling, rx capture on rising edges, tx bit select on falling edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            running  <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            tx_reg   <= RESET_TX;
            rx_reg   <= '0;
        end else begin
            if (load) begin
                mosi_q <= tx_reg[DATA_W-1];
            end
            if (start) begin
                running  <= 1'b1;
                div_cnt  <= '0;
                edge_cnt <= '0;
            end else if (running) begin
                if (tick) begin
                    div_cnt  <= '0;
                    sclk_q   <= ~sclk_q;
                    edge_cnt <= edge_cnt + 1'b1;
                    if (!sclk_q) begin
                        rx_reg <= {rx_reg[DATA_W-2:0], miso};
                    end else if (edge_cnt != LAST_EDGE) begin
                        mosi_q <= tx_reg[next_bit];
                    end
                    if (edge_cnt == LAST_EDGE) begin
                        running <= 1'b0;
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
            if (commit) begin
                tx_reg <= rx_reg;
                mosi_q <= 1'b0;
            end
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/renas_mcu_top.sv
// Autonomous SPI master: round-robins frames over four slaves, each frame
// transmitting the byte received in the previous one (first frame sends 8'hA5).
module renas_mcu_top
    import renas_mcu_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic miso_simo,
    output logic mosi_somi,
    output logic sclk,
    output logic ss_0,
    output logic ss_1,
    output logic ss_2,
    output logic ss_3
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES);

    state_e                state;
    logic [7:0]            cnt;
    logic [1:0]            idx;
    logic [NUM_SLAVES-1:0] ss;
    logic                  load;
    logic                  start;
    logic                  commit;
    logic                  done;

    assign load   = (state == IDLE)  && (cnt == GAP_LAST);
    assign start  = (state == SETUP) && (cnt == DIV_LAST);
    assign commit = (state == HOLD)  && (cnt == DIV_LAST);

    // Frame sequencer with registered selects.
    // Leaving HOLD preloads cnt with 1 so the select-high gap is exactly GAP_CYCLES,
    // while the reset path starts at 0 and so gives one extra cycle before ss_0 falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            ss    <= '1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state <= SETUP;
                        cnt   <= '0;
                        ss    <= sel_decode(idx);
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SETUP: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (done) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (commit) begin
                        state <= IDLE;
                        cnt   <= 8'd1;
                        ss    <= '1;
                        idx   <= idx + 2'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    ss    <= '1;
                end
            endcase
        end
    end

    renas_spi_shifter #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .start  (start),
        .commit (commit),
        .miso   (miso_simo),
        .sclk   (sclk),
        .mosi   (mosi_somi),
        .done   (done)
    );

    assign ss_0 = ss[0];
    assign ss_1 = ss[1];
    assign ss_2 = ss[2];
    assign ss_3 = ss[3];

endmodule

// File: tb/tb_renas_mcu_top.sv
// Bench for renas_mcu_top: a frame-level monitor plays the slave (random or planned
// bytes, changed on sclk falls) and checks timing, selects and the echo rule.
module tb_renas_mcu_top;

    localparam int unsigned D   = 4;
    localparam int unsigned GAP = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic miso_simo = 1'b0;
    logic mosi_somi;
    logic sclk;
    logic ss_0, ss_1, ss_2, ss_3;

    int total = 0;
    int bad   = 0;

    // Monitor / slave model state
    logic [3:0] ss_v;
    logic [3:0] prev_ss   = 4'hF;
    logic       prev_sclk = 1'b0;
    logic [3:0] exp_sel;
    logic [7:0] tx_byte;
    logic [7:0] miso_byte;
    logic [7:0] exp_tx    = 8'hA5;
    bit         in_frame  = 1'b0;
    int         cyc       = 0;
    int         low_cnt   = 0;
    int         gap_cnt   = 0;
    int         nrise     = 0;
    int         last_rise = 0;
    int         bitpos    = 0;
    int         exp_idx   = 0;
    int         m_frames  = 0;
    int         act_idx;
    logic [7:0] plan[$];
    logic [7:0] tx_log[$];
    int         idx_log[$];

    renas_mcu_top #(
        .CLK_DIV    (D),
        .GAP_CYCLES (GAP),
        .DATA_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .miso_simo (miso_simo),
        .mosi_somi (mosi_somi),
        .sclk      (sclk),
        .ss_0      (ss_0),
        .ss_1      (ss_1),
        .ss_2      (ss_2),
        .ss_3      (ss_3)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        for (int i = 0; i < 6000 && m_frames < n; i++) @(negedge clk);
        check_eq(tag, m_frames >= n, 1);
    endtask

    // Frame-level slave and checker, sampled on the falling clk edge
    always @(negedge clk) begin
        ss_v = {ss_3, ss_2, ss_1, ss_0};
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0;
            gap_cnt  = 0;
            nrise    = 0;
            exp_tx   = 8'hA5;
            exp_idx  = 0;
            m_frames = 0;
            tx_log.delete();
            idx_log.delete();
            prev_ss   = 4'hF;
            prev_sclk = 1'b0;
        end else begin
            if (ss_v != prev_ss) check_eq("sel_overlap", $countones(~ss_v) <= 1, 1);
            if (sclk != prev_sclk || ss_v != prev_ss)
                check_eq("sclk_idle_high", sclk & (ss_v == 4'hF), 0);

            if (prev_ss == 4'hF && ss_v != 4'hF) begin
                check_eq("gap_len", gap_cnt, GAP);
                exp_sel          = 4'hF;
                exp_sel[exp_idx] = 1'b0;
                check_eq("sel_idx", ss_v, exp_sel);
                act_idx = 0;
                for (int i = 0; i < 4; i++) if (!ss_v[i]) act_idx = i;
                idx_log.push_back(act_idx);
                in_frame  = 1'b1;
                low_cnt   = 0;
                nrise     = 0;
                tx_byte   = '0;
                miso_byte = (plan.size() > 0) ? plan.pop_front() : 8'($urandom);
                miso_simo = miso_byte[7];
                bitpos    = 6;
            end

            if (in_frame && ss_v != 4'hF) low_cnt++;

            if (in_frame && sclk && !prev_sclk) begin
                tx_byte = {tx_byte[6:0], mosi_somi};
                nrise++;
                if (nrise == 1) check_eq("setup_len", low_cnt, 2 * D + 1);
                else check_eq("sclk_period", cyc - last_rise, 2 * D);
                last_rise = cyc;
            end

            if (in_frame && !sclk && prev_sclk && bitpos >= 0) begin
                miso_simo = miso_byte[bitpos];
                bitpos--;
            end

            if (in_frame && prev_ss != 4'hF && ss_v == 4'hF) begin
                check_eq("sel_low_len", low_cnt, 18 * D);
                check_eq("sclk_pulses", nrise, 8);
                check_eq("echo_tx", tx_byte, exp_tx);
                check_eq("mosi_park", mosi_somi, 0);
                tx_log.push_back(tx_byte);
                exp_tx   = miso_byte;
                exp_idx  = (exp_idx + 1) % 4;
                m_frames++;
                in_frame = 1'b0;
                gap_cnt  = 0;
            end

            if (ss_v == 4'hF) gap_cnt++;
            prev_ss   = ss_v;
            prev_sclk = sclk;
        end
    end

    initial begin
        // Frame 0 sees miso=1, then 3C and 00 to exercise the echo path
        plan.push_back(8'hFF);
        plan.push_back(8'h3C);
        plan.push_back(8'h00);
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("rst_ss", {ss_3, ss_2, ss_1, ss_0}, 4'hF);
            check_eq("rst_sclk", sclk, 0);
            check_eq("rst_mosi", mosi_somi, 0);
        end
        #2 rst_n = 1'b1;

        wait_frames(5, "timeout_first5");
        if (tx_log.size() >= 4 && idx_log.size() >= 5) begin
            check_eq("frame0_tx", tx_log[0], 8'hA5);
            check_eq("frame1_tx", tx_log[1], 8'hFF);
            check_eq("frame2_tx", tx_log[2], 8'h3C);
            check_eq("frame3_tx", tx_log[3], 8'h00);
            for (int i = 0; i < 5; i++) check_eq("round_robin", idx_log[i], i % 4);
        end

        // Abort mid-frame after the 3rd sclk rise
        for (int i = 0; i < 2000 && !(in_frame && nrise == 3); i++) @(negedge clk);
        check_eq("midframe_reached", in_frame && nrise == 3, 1);
        check_eq("midframe_active", {ss_3, ss_2, ss_1, ss_0} != 4'hF, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_ss", {ss_3, ss_2, ss_1, ss_0}, 4'hF);
        check_eq("abort_sclk", sclk, 0);
        check_eq("abort_mosi", mosi_somi, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        wait_frames(1, "timeout_after_abort");
        if (tx_log.size() >= 1 && idx_log.size() >= 1) begin
            check_eq("abort_tx", tx_log[0], 8'hA5);
            check_eq("abort_idx", idx_log[0], 0);
        end

        // Random slave data for 50 further frames; the monitor checks each echo
        wait_frames(51, "timeout_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/renas_mcu_top.md
RENAS_MCU_TOP -- requirements
Module: renas_mcu_top

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sclk half-period; legal values are 2 to 255.
REQ-002 Parameter GAP_CYCLES, default 4: idle clk cycles between frames, with all selects deasserted; legal values are 1 to 255.
REQ-003 Parameter DATA_W, fixed at 8: SPI frame width in bits.
REQ-004 Port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port miso_simo, input, 1 bit: serial data from the slave.
REQ-007 Port mosi_somi, output, 1 bit: serial data to the slave, MSB first.
REQ-008 Port sclk, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-009 Ports ss_0, ss_1, ss_2, ss_3, output, 1 bit each: slave selects, active-low; at most one is low at any time.

Function
REQ-010 The block SHALL run as an autonomous SPI master that repeats frames forever after reset release.
REQ-011 Each frame SHALL target the slave index idx (0..3) and drive the matching ss_<idx> low.
REQ-012 idx SHALL advance by 1 after each frame and wrap from 3 to 0.
REQ-013 The state machine SHALL have four states: IDLE, SETUP, SHIFT, HOLD.
REQ-014 IDLE: hold all selects high and sclk=0 for GAP_CYCLES cycles, then enter SETUP.
REQ-015 SETUP: on entry, drive ss_<idx> low and mosi_somi=tx_reg[7]; after CLK_DIV cycles, enter SHIFT.
REQ-016 SHIFT: toggle sclk every CLK_DIV cycles, for 16 edges per frame.
REQ-017 On the clk edge that drives sclk high, the block SHALL shift the current miso_simo value into the LSB of rx_reg.
REQ-018 On each falling sclk edge except the 8th, mosi_somi SHALL present the next lower tx_reg bit.
REQ-019 After the 8th falling edge (sclk low), the block SHALL enter HOLD.
REQ-020 HOLD: keep ss_<idx> low for CLK_DIV cycles, then in one cycle: deassert ss_<idx>, load tx_reg<=rx_reg, set idx<=idx+1, drive mosi_somi=0, and enter IDLE.
REQ-021 Echo rule: the byte transmitted in frame N+1 SHALL equal the byte received in frame N.
REQ-022 The first frame after reset SHALL transmit 8'hA5.
REQ-023 Frame timing: select low for (2+16)*CLK_DIV cycles (72 at defaults); sclk period 2*CLK_DIV cycles; frame-to-frame period 18*CLK_DIV+GAP_CYCLES cycles (76 at defaults).
REQ-024 All outputs SHALL be registered and glitch-free.
REQ-025 sclk SHALL never be high while all selects are high.
REQ-026 miso_simo SHALL be used as-is with no synchronizer; the slave must change it on sclk falling edges.

Reset
REQ-027 While rst_n=0 (asynchronously): ss_0..ss_3=1, sclk=0, mosi_somi=0, state=IDLE, idx=0, tx_reg=8'hA5, rx_reg=0, and all counters=0.
REQ-028 Asserting rst_n mid-frame SHALL abort the frame immediately; no partial echo is kept.
REQ-029 After reset release, the first select SHALL fall GAP_CYCLES+1 clk edges later, on ss_0.

Structure
REQ-030 Package renas_mcu_pkg SHALL hold the state enum (IDLE, SETUP, SHIFT, HOLD), RESET_TX=8'hA5, and NUM_SLAVES=4.
REQ-031 Sub-module renas_spi_shifter SHALL hold the clock divider, sclk generation and the tx/rx shift registers, with start/done handshake signals.
REQ-032 renas_mcu_top SHALL hold the frame FSM, idx, and the one-hot select decode.

Verification
REQ-033 Reset: hold rst_n=0 for 5 cycles -> ss_0..3=1111, sclk=0, mosi_somi=0 throughout.
REQ-034 First frame (defaults, miso_simo=1): ss_0 low for 72 cycles; 8 sclk pulses with period 8; mosi_somi sampled on sclk rising edges = 1,0,1,0,0,1,0,1.
REQ-035 Echo: slave returns 8'h3C in frame 0 -> frame 1 on ss_1 transmits 8'h3C; slave returns 8'h00 -> next frame transmits 8'h00.
REQ-036 Round robin: 5 consecutive frames select ss_0, ss_1, ss_2, ss_3, ss_0; gap between frames = 4 cycles; selects never overlap.
REQ-037 Mid-frame reset: assert rst_n=0 after the 3rd sclk rise -> all selects high at once; after release, the next frame is on ss_0 with 8'hA5.
REQ-038 Random miso_simo changed on sclk falling edges for 50 frames: each frame's mosi_somi byte equals the previous frame's captured miso_simo byte.
